rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 104 ++++++++++
 tb/tb_rr_arbiter8.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-channel round-robin arbiter with bounded grant tenure.
// The granted index and enable are registered so they can drive a 3-to-8 decoder directly.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       grant_release,  // current grantee is done (ignored while en=0)
  output logic [2:0] a,
  output logic       en,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold;
  logic [2:0] pick;
  logic       stop_normal;
  logic       stop_limit;

  // First set request bit at or after p, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        res   = res;
        found = found;
      end
    end
    return res;
  endfunction

  // Next-grant choice and the two ways a tenure can end.
  always_comb begin
    pick        = rr_pick(req, ptr);
    stop_normal = grant_release | ~req[a];
    stop_limit  = (hold == HOLD_LAST);
  end

  // Arbiter state machine; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      a       <= 3'd0;
      en      <= 1'b0;
      timeout <= 1'b0;
      hold    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (req != 8'h00) begin
            a     <= pick;
            en    <= 1'b1;
            hold  <= 8'd0;
            state <= GRANT;
          end else begin
            en    <= 1'b0;
            state <= IDLE;
          end
        end
        GRANT: begin
          if (stop_normal || stop_limit) begin
            // A release or dropped request wins over the hold limit: no timeout then.
            state   <= IDLE;
            en      <= 1'b0;
            ptr     <= a + 3'd1;
            hold    <= 8'd0;
            timeout <= stop_limit & ~stop_normal;
          end else begin
            state   <= GRANT;
            en      <= 1'b1;
            hold    <= hold + 8'd1;
            timeout <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          en      <= 1'b0;
          timeout <= 1'b0;
          hold    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: MAX_HOLD=4 main instance plus a MAX_HOLD=1 instance.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       grant_release;
  logic [2:0] a4;
  logic       en4;
  logic       to4;
  logic [2:0] a1;
  logic       en1;
  logic       to1;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .a(a4), .en(en4), .timeout(to4)
  );

  rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .a(a1), .en(en1), .timeout(to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {en, a, timeout} of the MAX_HOLD=4 instance.
  task automatic exp4(input string tag, input logic e, input logic [2:0] aa, input logic t);
    check(tag, {3'b000, en4, a4, to4}, {3'b000, e, aa, t});
  endtask

  task automatic exp1(input string tag, input logic e, input logic [2:0] aa, input logic t);
    check(tag, {3'b000, en1, a1, to1}, {3'b000, e, aa, t});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst_n         = 1'b0;
    req           = r;
    grant_release = 1'b0;
    @(posedge clk);
    #1;
    exp4("reset_state", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Continuous monitor: a stable during a tenure, tenure never longer than 4,
  // and one-cycle grants of the MAX_HOLD=1 instance always separated by a gap.
  logic       prev_en4;
  logic [2:0] prev_a4;
  logic       prev_en1;
  int         run4;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en4 = 1'b0;
      prev_en1 = 1'b0;
      prev_a4  = 3'd0;
      run4     = 0;
    end else begin
      if (en4 && prev_en4) check("a_stable", {5'd0, a4}, {5'd0, prev_a4});
      run4 = en4 ? run4 + 1 : 0;
      if (en4) check("run_len_le4", {7'd0, (run4 > 4)}, 8'd0);
      check("dut1_gap", {7'd0, (en1 & prev_en1)}, 8'd0);
      prev_en4 = en4;
      prev_a4  = a4;
      prev_en1 = en1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 8'h00; grant_release = 1'b0;
    #12;

    // Single requester, hold-limit expiry then re-grant.
    do_reset(8'h01);
    step(); exp4("a_first", 1'b1, 3'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin step(); exp4("a_hold", 1'b1, 3'd0, 1'b0); end
    step(); exp4("a_timeout", 1'b0, 3'd0, 1'b1);
    step(); exp4("a_regrant", 1'b1, 3'd0, 1'b0);

    // Channels 0 and 7 alternate, each tenure ending by timeout.
    do_reset(8'h81);
    for (int g = 0; g < 4; g++) begin
      logic [2:0] ea;
      ea = (g % 2 == 0) ? 3'd0 : 3'd7;
      step(); exp4("b_grant", 1'b1, ea, 1'b0);
      for (int c = 0; c < 3; c++) begin step(); exp4("b_hold", 1'b1, ea, 1'b0); end
      step(); exp4("b_gap", 1'b0, ea, 1'b1);
    end

    // All requesting, release on first cycle of each grant.
    do_reset(8'hFF);
    for (int g = 0; g < 9; g++) begin
      step(); exp4("c_grant", 1'b1, 3'(g % 8), 1'b0);
      grant_release = 1'b1;
      step(); exp4("c_gap", 1'b0, 3'(g % 8), 1'b0);
      grant_release = 1'b0;
    end

    // Drop at 2nd cycle, then release and drop coincident with the hold limit.
    do_reset(8'h08);
    step(); exp4("d_grant", 1'b1, 3'd3, 1'b0);
    step(); exp4("d_cyc2", 1'b1, 3'd3, 1'b0);
    req = 8'h00;
    step(); exp4("d_drop", 1'b0, 3'd3, 1'b0);
    req = 8'h08;
    step(); exp4("d_grant2", 1'b1, 3'd3, 1'b0);
    step(); step(); step(); exp4("d_cyc4", 1'b1, 3'd3, 1'b0);
    grant_release = 1'b1;
    step(); exp4("d_rel_at_limit", 1'b0, 3'd3, 1'b0);
    grant_release = 1'b0;
    step(); exp4("d_grant3", 1'b1, 3'd3, 1'b0);
    step(); step(); step();
    req = 8'h00;
    step(); exp4("d_drop_at_limit", 1'b0, 3'd3, 1'b0);
    step(); exp4("d_idle_hold_a", 1'b0, 3'd3, 1'b0);

    // Asynchronous reset mid-grant on channel 5.
    do_reset(8'h20);
    step(); exp4("e_grant5", 1'b1, 3'd5, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1 exp4("e_async_rst", 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(); exp4("e_regrant5", 1'b1, 3'd5, 1'b0);
    do_reset(8'hFF);
    step(); exp4("e_from_ch0", 1'b1, 3'd0, 1'b0);

    // Reset during the last tenure cycle must not produce a timeout.
    do_reset(8'h01);
    step(); step(); step(); step(); exp4("e2_cyc4", 1'b1, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    exp4("e2_no_timeout", 1'b0, 3'd0, 1'b0);

    // Request changes during a grant are ignored; pointer moves past the grantee.
    do_reset(8'h02);
    step(); exp4("f_grant1", 1'b1, 3'd1, 1'b0);
    req = 8'h03;
    for (int c = 0; c < 3; c++) begin step(); exp4("f_hold1", 1'b1, 3'd1, 1'b0); end
    step(); exp4("f_timeout", 1'b0, 3'd1, 1'b1);
    step(); exp4("f_wrap_to0", 1'b1, 3'd0, 1'b0);

    // MAX_HOLD=1 instance.
    do_reset(8'h01);
    step(); exp1("g_grant", 1'b1, 3'd0, 1'b0);
    step(); exp1("g_timeout", 1'b0, 3'd0, 1'b1);
    step(); exp1("g_regrant", 1'b1, 3'd0, 1'b0);
    grant_release = 1'b1;
    step(); exp1("g_released", 1'b0, 3'd0, 1'b0);
    grant_release = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
